// File: rtl/alu_pkg.sv
// Shared ALU opcode values and execute-stage occupancy encoding.
// The opcode values are also used by the ALU control decoder.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath.
// Maps aluop and two operands to a result, a zero flag and an illegal flag.
import alu_pkg::*;

module alu_core #(
  parameter int XLEN = 32
) (
  input  logic [3:0]      aluop,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  logic lt;

  assign lt = $signed(src_a) < $signed(src_b);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    unique case (1'b1)
      (aluop == ALU_AND): result = src_a & src_b;
      (aluop == ALU_OR):  result = src_a | src_b;
      (aluop == ALU_ADD): result = src_a + src_b;
      (aluop == ALU_SUB): result = src_a - src_b;
      (aluop == ALU_SLT): result = {{(XLEN-1){1'b0}}, lt};
      (aluop == ALU_NOR): result = ~(src_a | src_b);
      default:            illegal = 1'b1;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with a two-entry skid buffer.
// in_ready depends only on registered occupancy, never on out_ready.
import alu_pkg::*;

module alu_exec #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluop,
  input  logic [XLEN-1:0]  src_a,
  input  logic [XLEN-1:0]  src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             zero,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_count
);

  occ_e state, state_nxt;

  logic [XLEN-1:0] core_res;
  logic            core_zero;
  logic            core_ill;

  logic [XLEN-1:0] main_res, skid_res;
  logic            main_zero, skid_zero;
  logic            main_ill, skid_ill;

  logic accept, drain;
  logic load_main, load_skid, move_skid;

  alu_core #(
    .XLEN(XLEN)
  ) u_core (
    .aluop  (aluop),
    .src_a  (src_a),
    .src_b  (src_b),
    .result (core_res),
    .zero   (core_zero),
    .illegal(core_ill)
  );

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_nxt = TWO;
          load_skid = 1'b1;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          state_nxt = ONE;
          move_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= EMPTY;
      main_res      <= '0;
      main_zero     <= 1'b0;
      main_ill      <= 1'b0;
      skid_res      <= '0;
      skid_zero     <= 1'b0;
      skid_ill      <= 1'b0;
      retired_count <= '0;
    end else begin
      state <= state_nxt;
      if (load_main) begin
        main_res  <= core_res;
        main_zero <= core_zero;
        main_ill  <= core_ill;
      end else if (move_skid) begin
        main_res  <= skid_res;
        main_zero <= skid_zero;
        main_ill  <= skid_ill;
      end
      if (load_skid) begin
        skid_res  <= core_res;
        skid_zero <= core_zero;
        skid_ill  <= core_ill;
      end
      if (drain) begin
        retired_count <= retired_count + 1'b1;
      end
    end
  end

  assign result  = main_res;
  assign zero    = main_zero;
  assign illegal = main_ill;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec.
// Inputs are driven and outputs sampled on the falling edge.
module tb_alu_exec;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  aluop;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic [15:0] retired_count;

  int vec;
  int err;

  alu_exec #(
    .XLEN (32),
    .CNT_W(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .aluop        (aluop),
    .src_a        (src_a),
    .src_b        (src_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .zero         (zero),
    .illegal      (illegal),
    .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  logic [3:0]  t_op  [11] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                             4'b1100, 4'b0010, 4'b0111, 4'b0111,
                             4'b0011, 4'b0010, 4'b1111};
  logic [31:0] t_a   [11] = '{32'd5, 32'd9, 32'hF0F0F0F0, 32'd1,
                             32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,
                             32'd3, 32'd1, 32'd7};
  logic [31:0] t_b   [11] = '{32'd7, 32'd9, 32'h0FF00FF0, 32'd2,
                             32'd0, 32'd1, 32'd1, 32'hFFFFFFFF,
                             32'd4, 32'd1, 32'd8};
  logic [31:0] t_res [11] = '{32'd12, 32'd0, 32'h00F000F0, 32'd3,
                             32'hFFFFFFFF, 32'd0, 32'd1, 32'd0,
                             32'd0, 32'd2, 32'd0};
  logic        t_z   [11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                             1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic        t_il  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                             1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    aluop     = 4'd0;
    src_a     = '0;
    src_b     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vec++;
    if (out_valid !== 1'b0 || result !== 32'd0 ||
        zero !== 1'b0 || illegal !== 1'b0) begin
      $display("FAIL reset_outputs: got v=%b r=%h z=%b i=%b want 0",
               out_valid, result, zero, illegal);
      err++;
    end
    vec++;
    if (retired_count !== 16'd0 || in_ready !== 1'b1) begin
      $display("FAIL reset_cnt_rdy: got cnt=%0d rdy=%b want 0/1",
               retired_count, in_ready);
      err++;
    end
  endtask

  task automatic test_ops();
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1;
      aluop    = t_op[i];
      src_a    = t_a[i];
      src_b    = t_b[i];
      @(negedge clk);
      in_valid = 1'b0;
      aluop    = 4'b0110;
      src_a    = 32'hDEADBEEF;
      vec++;
      if (out_valid !== 1'b1 || result !== t_res[i] ||
          zero !== t_z[i] || illegal !== t_il[i]) begin
        $display("FAIL op%0d: got v=%b r=%h z=%b i=%b want 1 %h %b %b",
                 i, out_valid, result, zero, illegal,
                 t_res[i], t_z[i], t_il[i]);
        err++;
      end
      @(negedge clk);
      vec++;
      if (out_valid !== 1'b0) begin
        $display("FAIL op%0d_drained: got v=%b want 0", i, out_valid);
        err++;
      end
      if (i == 5) begin
        vec++;
        if (retired_count !== 16'd6) begin
          $display("FAIL count_6: got %0d want 6", retired_count);
          err++;
        end
      end
    end
    vec++;
    if (retired_count !== 16'd11) begin
      $display("FAIL count_11: got %0d want 11", retired_count);
      err++;
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    aluop     = 4'b0010;
    src_a     = 32'd10;
    src_b     = 32'd1;
    @(negedge clk);
    vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || result !== 32'd11) begin
      $display("FAIL bp_a: got rdy=%b v=%b r=%h want 1 1 0000000b",
               in_ready, out_valid, result);
      err++;
    end
    aluop = 4'b0110;
    src_a = 32'd20;
    src_b = 32'd5;
    @(negedge clk);
    vec++;
    if (in_ready !== 1'b0 || result !== 32'd11) begin
      $display("FAIL bp_full: got rdy=%b r=%h want 0 0000000b",
               in_ready, result);
      err++;
    end
    aluop = 4'b0001;
    src_a = 32'h100;
    src_b = 32'h011;
    @(negedge clk);
    vec++;
    if (in_ready !== 1'b0 || result !== 32'd11 || out_valid !== 1'b1) begin
      $display("FAIL bp_stall: got rdy=%b v=%b r=%h want 0 1 0000000b",
               in_ready, out_valid, result);
      err++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    vec++;
    if (in_ready !== 1'b1 || result !== 32'd15) begin
      $display("FAIL bp_b: got rdy=%b r=%h want 1 0000000f",
               in_ready, result);
      err++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    vec++;
    if (out_valid !== 1'b1 || result !== 32'h111) begin
      $display("FAIL bp_c: got v=%b r=%h want 1 00000111",
               out_valid, result);
      err++;
    end
    @(negedge clk);
    vec++;
    if (out_valid !== 1'b0 || retired_count !== 16'd14) begin
      $display("FAIL bp_end: got v=%b cnt=%0d want 0 14",
               out_valid, retired_count);
      err++;
    end
  endtask

  task automatic test_stream();
    logic [3:0]  ops [6] = '{4'b0000, 4'b0001, 4'b0010,
                             4'b0110, 4'b0111, 4'b1100};
    logic [31:0] exp_q [$];
    logic [31:0] e;
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      if (i > 0) begin
        e = exp_q.pop_front();
        vec++;
        if (out_valid !== 1'b1 || result !== e ||
            zero !== (e == 32'd0)) begin
          $display("FAIL stream%0d: got v=%b r=%h z=%b want 1 %h",
                   i - 1, out_valid, result, zero, e);
          err++;
        end
      end
      if (i < 100) begin
        in_valid = 1'b1;
        aluop    = ops[$urandom_range(0, 5)];
        src_a    = $urandom;
        src_b    = ($urandom_range(0, 3) == 0) ? src_a : $urandom;
        exp_q.push_back(model(aluop, src_a, src_b));
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    vec++;
    if (retired_count !== 16'd100 || out_valid !== 1'b0) begin
      $display("FAIL stream_count: got cnt=%0d v=%b want 100 0",
               retired_count, out_valid);
      err++;
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    aluop     = 4'b0010;
    src_a     = 32'd40;
    src_b     = 32'd2;
    @(negedge clk);
    src_a = 32'd50;
    @(negedge clk);
    vec++;
    if (in_ready !== 1'b0) begin
      $display("FAIL mid_full: got rdy=%b want 0", in_ready);
      err++;
    end
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    vec++;
    if (out_valid !== 1'b0 || retired_count !== 16'd0 ||
        in_ready !== 1'b1) begin
      $display("FAIL mid_reset: got v=%b cnt=%0d rdy=%b want 0 0 1",
               out_valid, retired_count, in_ready);
      err++;
    end
    repeat (3) begin
      @(negedge clk);
      vec++;
      if (out_valid !== 1'b0 || retired_count !== 16'd0) begin
        $display("FAIL mid_ghost: got v=%b cnt=%0d want 0 0",
                 out_valid, retired_count);
        err++;
      end
    end
  endtask

  initial begin
    vec = 0;
    err = 0;
    test_reset();
    test_ops();
    test_backpressure();
    test_stream();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
